// File: rtl/press_classifier_if.sv
// Debounced level in, gesture ticks and busy out, for the press classifier.
interface press_classifier_if;
  logic db_level;
  logic short_tick;
  logic long_tick;
  logic double_tick;
  logic busy;

  modport master (output db_level, input short_tick, long_tick, double_tick, busy);
  modport slave  (input db_level, output short_tick, long_tick, double_tick, busy);
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced presses as short / long / double and emits one registered tick per gesture.
// One counter serves both the hold timer and the release-gap timer.
module press_classifier #(
  parameter int unsigned LONG_CNT = 4_000_000,
  parameter int unsigned GAP_CNT  = 2_000_000,
  parameter int unsigned W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  press_classifier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} state_t;

  localparam logic [W-1:0] LONG_TERM = W'(LONG_CNT - 1);
  localparam logic [W-1:0] GAP_TERM  = W'(GAP_CNT - 1);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic         short_q, long_q, double_q;
  logic         short_nxt, long_nxt, double_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
      double_q <= double_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: if (bus.db_level) begin
        state_nxt = PRESS1;
        cnt_nxt   = '0;
      end
      PRESS1: begin
        if (!bus.db_level) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_TERM) begin
          state_nxt = HELD;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // A press on the timeout edge still counts as the second press.
      GAP: begin
        if (bus.db_level) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_TERM) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (!bus.db_level) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end else if (cnt == LONG_TERM) begin
          state_nxt  = HELD;
          double_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: if (!bus.db_level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.short_tick  = short_q;
  assign bus.long_tick   = long_q;
  assign bus.double_tick = double_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed gestures against a run-length reference model of the classifier.
module tb_press_classifier;
  localparam int LONG_CNT = 8;
  localparam int GAP_CNT  = 4;

  logic clk = 1'b0;
  logic reset;
  press_classifier_if bus ();

  press_classifier #(.LONG_CNT(LONG_CNT), .GAP_CNT(GAP_CNT), .W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_short = 0, n_long = 0, n_double = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs seen by the DUT at each rising edge.
  logic s_lvl, s_rst;
  always @(posedge clk) begin
    s_lvl <= bus.db_level;
    s_rst <= reset;
  end

  // Reference model: phase of the gesture plus length of the current run of equal samples.
  // 0 idle, 1 first press, 2 release gap, 3 second press, 4 held until release
  int ph = 0;
  int run = 0;
  logic e_s, e_l, e_d;

  task automatic model_step();
    e_s = 0; e_l = 0; e_d = 0;
    if (s_rst) ph = 0;
    else case (ph)
      0: if (s_lvl) begin ph = 1; run = 1; end
      1: if (!s_lvl) begin ph = 2; run = 1; end
         else begin run++; if (run == LONG_CNT + 1) begin ph = 4; e_l = 1; end end
      2: if (s_lvl) begin ph = 3; run = 1; end
         else begin run++; if (run == GAP_CNT + 1) begin ph = 0; e_s = 1; end end
      3: if (!s_lvl) begin ph = 0; e_d = 1; end
         else begin run++; if (run == LONG_CNT + 1) begin ph = 4; e_d = 1; end end
      default: if (!s_lvl) ph = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      chk("short_tick",  32'(bus.short_tick),  32'(e_s));
      chk("long_tick",   32'(bus.long_tick),   32'(e_l));
      chk("double_tick", 32'(bus.double_tick), 32'(e_d));
      chk("busy",        32'(bus.busy),        32'(ph != 0));
      if (bus.short_tick === 1'b1)  n_short++;
      if (bus.long_tick === 1'b1)   n_long++;
      if (bus.double_tick === 1'b1) n_double++;
    end
  end

  task automatic hold(input logic lvl, input int n);
    repeat (n) begin
      bus.db_level = lvl;
      @(posedge clk);
      #2;
    end
  endtask

  int b_s, b_l, b_d;
  task automatic mark();
    b_s = n_short; b_l = n_long; b_d = n_double;
  endtask

  task automatic expect_ticks(input string tag, input int s, input int l, input int d);
    chk({tag, "_short_cnt"},  32'(n_short - b_s),  32'(s));
    chk({tag, "_long_cnt"},   32'(n_long - b_l),   32'(l));
    chk({tag, "_double_cnt"}, 32'(n_double - b_d), 32'(d));
  endtask

  initial begin
    logic lvl;
    reset = 1'b1;
    bus.db_level = 1'b0;
    hold(1'b0, 2);
    reset = 1'b0;
    mark();
    hold(1'b0, 50);
    expect_ticks("idle", 0, 0, 0);

    mark(); hold(1'b1, 3); hold(1'b0, 10);
    expect_ticks("short", 1, 0, 0);

    mark(); hold(1'b1, 20); hold(1'b0, 6);
    expect_ticks("long", 0, 1, 0);

    mark(); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 6);
    expect_ticks("double", 0, 0, 1);

    mark(); hold(1'b1, 2); hold(1'b0, 4); hold(1'b1, 2); hold(1'b0, 8);
    expect_ticks("gap_edge", 0, 0, 1);

    mark(); hold(1'b1, 2); hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 10);
    expect_ticks("gap_past", 2, 0, 0);

    // Reset with cnt=5 in the first press; level stays high and is taken as a new press.
    mark(); hold(1'b1, 6);
    reset = 1'b1; hold(1'b1, 1); reset = 1'b0;
    hold(1'b1, 12); hold(1'b0, 6);
    expect_ticks("rst_mid", 0, 1, 0);

    lvl = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        hold(1'($urandom_range(0, 1)), 1);
        reset = 1'b0;
      end
      hold(lvl, int'($urandom_range(1, 12)));
      lvl = ~lvl;
    end
    hold(1'b0, 20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/press_classifier.md
# press_classifier

Downstream stage for the switch debouncer FSMD. It consumes the debounced `db_level` and classifies each user gesture as a short press, long press or double press. Each class is reported as a one-cycle, registered tick that feeds the control FSMs directly. Counting is cycle-based, so a single counter serves both the hold timer and the release-gap timer.

## Interface
- `LONG_CNT`, default 24'd4_000_000: number of cycles the first press must be held to count as a long press; must be ≥2.
- `GAP_CNT`, default 24'd2_000_000: maximum release gap, in cycles, that still forms a double press; must be ≥2.
- `W`, default 24: counter width; must satisfy 2^W > max(LONG_CNT, GAP_CNT).
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high; takes effect at the rising edge of `clk`.
- `db_level`  in  1  debounced switch level from the debouncer; 1 means pressed.
- `short_tick`  out  1  one-cycle pulse: single short press completed.
- `long_tick`  out  1  one-cycle pulse: first press held for `LONG_CNT` cycles.
- `double_tick`  out  1  one-cycle pulse: second press detected inside the gap window.
- `busy`  out  1  high whenever the state is not IDLE; decoded from the state register.

## Operation
- States: IDLE, PRESS1, GAP, PRESS2, HELD. The block has one `W`-bit counter `cnt`.
- Reset: state goes to IDLE, `cnt` to 0, and all ticks to 0. `busy` is 0 after reset.
- IDLE: if `db_level`=1, go to PRESS1 with `cnt`←0. Otherwise stay.
- PRESS1:
  - If `db_level`=0, go to GAP with `cnt`←0.
  - Else if `cnt`==LONG_CNT-1, go to HELD and set `long_tick`←1.
  - Else `cnt`←`cnt`+1.
- GAP:
  - If `db_level`=1, go to PRESS2. This check has priority over the timeout.
  - Else if `cnt`==GAP_CNT-1, go to IDLE and set `short_tick`←1.
  - Else `cnt`←`cnt`+1.
- PRESS2:
  - If `db_level`=0, go to IDLE and set `double_tick`←1.
  - Else if `cnt`==LONG_CNT-1, go to HELD and set `double_tick`←1. A held second press is still a double press.
  - Else `cnt`←`cnt`+1. `cnt` is cleared on entry to PRESS2.
- HELD: if `db_level`=0, go to IDLE. Otherwise stay. No tick is issued on this release.
- Each gesture produces exactly one tick. At most one tick is high in any cycle.
- Ticks are registered. Each tick defaults to 0 every cycle and is high only in the cycle after the deciding edge.
- `cnt` never wraps: every counting state exits at its terminal value before overflow.
- Reset during any state aborts the gesture without emitting a tick.
  - If `db_level` is still 1 after reset, the next edge enters PRESS1. The held level is treated as a fresh press.

## Timing
- Edge `k` is the first edge that samples `db_level`=1 in IDLE; PRESS1 is entered at edge `k`.
- Long press: if `db_level` stays 1, the deciding edge is `k`+LONG_CNT. `long_tick` is high for the one cycle after that edge. In total, `db_level` is sampled high on LONG_CNT+1 consecutive edges.
- Short press:
  - Edge `r` is the first edge that samples 0 in PRESS1; GAP is entered at edge `r`.
  - If `db_level` stays 0, the timeout edge is `r`+GAP_CNT. `short_tick` is high for the cycle after it.
- Double press:
  - A second press sampled at any edge `r`+1 … `r`+GAP_CNT enters PRESS2. Edge `r`+GAP_CNT is included because level has priority over timeout.
  - `double_tick` follows at the release edge of the second press, or at the edge where the second press reaches its LONG_CNT terminal value.
- Latency from the deciding edge to the tick is one cycle. No backpressure; consumers must sample ticks every cycle.
- `busy` rises one cycle after edge `k`. It falls in the cycle after the edge that enters IDLE, which is the same cycle that `short_tick` or `double_tick` is high.

## Test plan
Bench parameters: LONG_CNT=8, GAP_CNT=4, W=4.
- Reset test: assert `reset` for 2 cycles with `db_level`=0 → all ticks 0, `busy`=0. Then hold `db_level`=0 for 50 cycles → no tick.
- Single short press: `db_level`=1 for 3 edges, then 0 at edge `r` → `short_tick`=1 only in the cycle after edge `r`+4. `long_tick` and `double_tick` stay 0; `busy` drops with the tick.
- Long press: `db_level`=1 from edge `k` for 20 cycles → `long_tick` pulses exactly once, in the cycle after edge `k`+8. The later release produces no tick.
- Double press: high 2 edges, low 2 edges, high 2 edges, then low at edge `s` → `double_tick`=1 in the cycle after edge `s`. No `short_tick` in the sequence.
- Gap boundary: second press first sampled at edge `r`+4 → `double_tick` after its release and no `short_tick`. Repeat with the press first sampled at `r`+5 → `short_tick` after edge `r`+4, then the second press is classified on its own as a new gesture.
- Reset mid-press: assert `reset` at PRESS1 with `cnt`=5 while `db_level` stays 1 → no tick, `busy`=0 after reset. The next edge re-enters PRESS1, and `long_tick` follows 8 edges later.
